// File: rtl/cpack_line_ctrl.sv
// +-----------------------------------------------------------------------------+
// | cpack_line_ctrl: sequences one 512-bit line into stage1and2 as word pairs   |
// | and totals the returned lengths. Option macro: CPACK_EARLY_ABORT_EN         |
// | Rev 1.0                                                                     |
// +-----------------------------------------------------------------------------+
`timescale 1ns/1ps
`default_nettype none

module cpack_line_ctrl #(
  parameter int WIDTH      = 64,
  parameter int CACHE_LINE = 512,
  parameter int LAT        = 2,
  parameter int THRESH     = 448,
  parameter int LEN_W      = 10
) (
  input  logic                  i_clk,
  input  logic                  i_reset,
  input  logic [CACHE_LINE-1:0] i_line,
  input  logic                  i_line_valid,
  output logic                  o_line_ready,
  output logic [WIDTH-1:0]      o_word,
  output logic                  o_word_valid,
  output logic                  o_dict_clr,
  input  logic [6:0]            i_total_length,
  input  logic                  i_stall,
  output logic                  o_done_valid,
  input  logic                  i_done_ready,
  output logic [LEN_W-1:0]      o_comp_bits,
  output logic                  o_incompressible,
  output logic                  o_busy
);

  localparam int PAIRS = CACHE_LINE / WIDTH;
  localparam int IDX_W = (PAIRS > 1) ? $clog2(PAIRS) : 1;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_CLEAR = 3'd1,
    S_FEED  = 3'd2,
    S_DRAIN = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  state_t                r_state;
  logic [CACHE_LINE-1:0] r_line;
  logic [IDX_W-1:0]      r_idx;
  logic [WIDTH-1:0]      r_last_word;
  logic [LEN_W-1:0]      r_acc;
  logic [LAT-1:0]        r_inflight;

  logic [WIDTH-1:0]      w_pairs [PAIRS];
  logic [LAT-1:0]        w_inflight_next;
  logic [LEN_W-1:0]      w_len_ext;
  logic                  w_over;
  logic                  w_abort;
  logic                  w_issue;
  logic                  w_tap;

  genvar k;
  generate
    for (k = 0; k < PAIRS; k++) begin : g_pairs
      assign w_pairs[k] = r_line[k*WIDTH +: WIDTH];
    end
  endgenerate

  assign w_over = (r_acc > LEN_W'(THRESH));

`ifdef CPACK_EARLY_ABORT_EN
  // Stop issuing as soon as the registered total already exceeds the verdict threshold.
  assign w_abort = (r_state == S_FEED) && w_over;
`else
  assign w_abort = 1'b0;
`endif

  assign w_issue   = (r_state == S_FEED) && !i_stall && !w_abort;
  assign w_tap     = r_inflight[LAT-1];
  assign w_len_ext = {{(LEN_W-7){1'b0}}, i_total_length};

  generate
    if (LAT == 1) begin : g_lat1
      assign w_inflight_next = w_issue;
    end else begin : g_latn
      assign w_inflight_next = {r_inflight[LAT-2:0], w_issue};
    end
  endgenerate

  // A stalled cycle keeps presenting the previously issued pair.
  assign o_word       = w_issue ? w_pairs[r_idx] : r_last_word;
  assign o_word_valid = w_issue;

  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      r_state     <= S_IDLE;
      r_line      <= '0;
      r_idx       <= '0;
      r_last_word <= '0;
      r_acc       <= '0;
      r_inflight  <= '0;
    end else begin
      r_inflight <= w_inflight_next;
      if (w_tap) begin
        r_acc <= r_acc + w_len_ext;
      end
      if (w_issue) begin
        r_last_word <= o_word;
      end
      case (r_state)
        S_IDLE: begin
          if (i_line_valid) begin
            r_line  <= i_line;
            r_state <= S_CLEAR;
          end
        end
        S_CLEAR: begin
          r_acc   <= '0;
          r_idx   <= '0;
          r_state <= S_FEED;
        end
        S_FEED: begin
          if (w_abort) begin
            r_state <= S_DRAIN;
          end else if (w_issue) begin
            if (r_idx == IDX_W'(PAIRS-1)) begin
              r_state <= S_DRAIN;
            end else begin
              r_idx <= r_idx + 1'b1;
            end
          end
        end
        // The last in-flight length is added on the same edge that enters DONE.
        S_DRAIN: begin
          if (w_inflight_next == '0) begin
            r_state <= S_DONE;
          end
        end
        S_DONE: begin
          if (i_done_ready) begin
            r_state <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign o_line_ready     = (r_state == S_IDLE);
  assign o_dict_clr       = (r_state == S_CLEAR);
  assign o_done_valid     = (r_state == S_DONE);
  assign o_comp_bits      = (r_state == S_DONE) ? r_acc : '0;
  assign o_incompressible = (r_state == S_DONE) && w_over;
  assign o_busy           = (r_state != S_IDLE);

endmodule

`default_nettype wire

// File: tb/tb_cpack_line_ctrl.sv
// Testbench for cpack_line_ctrl: cycle-by-cycle vector tables plus a mid-line reset.
// Build with CPACK_EARLY_ABORT_EN to exercise the early-abort path at THRESH = 200.
`timescale 1ns/1ps
`default_nettype none

module tb_cpack_line_ctrl;

  localparam int LAT   = 2;
  localparam int LEN_W = 10;
`ifdef CPACK_EARLY_ABORT_EN
  localparam int   THRESH = 200;
  localparam logic BIG    = 1'b0;
`else
  localparam int   THRESH = 448;
  localparam logic BIG    = 1'b1;
`endif

  logic             clk;
  logic             i_reset;
  logic [511:0]     i_line;
  logic             i_line_valid;
  logic             o_line_ready;
  logic [63:0]      o_word;
  logic             o_word_valid;
  logic             o_dict_clr;
  logic [6:0]       i_total_length;
  logic             i_stall;
  logic             o_done_valid;
  logic             i_done_ready;
  logic [LEN_W-1:0] o_comp_bits;
  logic             o_incompressible;
  logic             o_busy;

  cpack_line_ctrl #(
    .WIDTH(64), .CACHE_LINE(512), .LAT(LAT), .THRESH(THRESH), .LEN_W(LEN_W)
  ) dut (
    .i_clk(clk), .i_reset(i_reset), .i_line(i_line), .i_line_valid(i_line_valid),
    .o_line_ready(o_line_ready), .o_word(o_word), .o_word_valid(o_word_valid),
    .o_dict_clr(o_dict_clr), .i_total_length(i_total_length), .i_stall(i_stall),
    .o_done_valid(o_done_valid), .i_done_ready(i_done_ready), .o_comp_bits(o_comp_bits),
    .o_incompressible(o_incompressible), .o_busy(o_busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Datapath stand-in: zero pair compresses to 4 bits, any nonzero pair here to 68.
  // Non-issue slots return a junk value the controller must ignore.
  logic [6:0] lpipe [LAT];
  always @(posedge clk) begin
    lpipe[0] <= o_word_valid ? ((o_word == 64'd0) ? 7'd4 : 7'd68) : 7'h55;
    for (int i = 1; i < LAT; i++) lpipe[i] <= lpipe[i-1];
  end
  assign i_total_length = lpipe[LAT-1];

  typedef struct {
    logic       lv;
    logic       sel;
    logic       stall;
    logic       dr;
    logic       e_ready;
    logic       e_clr;
    logic       e_wv;
    logic       e_done;
    int         e_pair;
    logic [9:0] e_bits;
    logic       e_inc;
  } vec_t;

  vec_t         tbl[$];
  int           errors = 0;
  int           checks = 0;
  logic [511:0] line_zero;
  logic [511:0] line_dist;
  logic [511:0] active_line;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic add(input logic lv, input logic sel, input logic stall, input logic dr,
                     input logic er, input logic ec, input logic ewv, input logic ed,
                     input int ep, input logic [9:0] bits, input logic inc);
    vec_t v;
    v.lv = lv; v.sel = sel; v.stall = stall; v.dr = dr;
    v.e_ready = er; v.e_clr = ec; v.e_wv = ewv; v.e_done = ed;
    v.e_pair = ep; v.e_bits = bits; v.e_inc = inc;
    tbl.push_back(v);
  endtask

  // Unstalled line: accept in c0, clear c1, pairs c2..c9, result c12, idle c13.
  // 'so' raises i_stall in every non-FEED cycle, which must change nothing.
  task automatic nominal(input logic sel, input logic [9:0] bits, input logic inc,
                         input logic so, input logic skip0);
    if (!skip0) add(1, sel, so, 0, 1, 0, 0, 0, -1, 0, 0);
    add(0, sel, so, 0, 0, 1, 0, 0, -1, 0, 0);
    for (int p = 0; p < 8; p++) add(0, sel, 0, 0, 0, 0, 1, 0, p, 0, 0);
    add(0, sel, so, 0, 0, 0, 0, 0, -1, 0, 0);
    add(0, sel, so, 0, 0, 0, 0, 0, -1, 0, 0);
    add(0, sel, so, 1, 0, 0, 0, 1, -1, bits, inc);
    add(0, sel, 0, 0, 1, 0, 0, 0, -1, 0, 0);
  endtask

  task automatic run_table(input string tag);
    for (int c = 0; c < tbl.size(); c++) begin
      vec_t v;
      v = tbl[c];
      i_line       = v.sel ? line_dist : line_zero;
      i_line_valid = v.lv;
      i_stall      = v.stall;
      i_done_ready = v.dr;
      if (v.lv && v.e_ready) active_line = i_line;
      @(negedge clk);
      chk($sformatf("%s c%0d line_ready", tag, c), 64'(o_line_ready), 64'(v.e_ready));
      chk($sformatf("%s c%0d busy", tag, c), 64'(o_busy), 64'(!v.e_ready));
      chk($sformatf("%s c%0d dict_clr", tag, c), 64'(o_dict_clr), 64'(v.e_clr));
      chk($sformatf("%s c%0d word_valid", tag, c), 64'(o_word_valid), 64'(v.e_wv));
      chk($sformatf("%s c%0d done_valid", tag, c), 64'(o_done_valid), 64'(v.e_done));
      if (v.e_pair >= 0)
        chk($sformatf("%s c%0d word", tag, c), o_word, active_line[v.e_pair*64 +: 64]);
      if (v.e_done) begin
        chk($sformatf("%s c%0d comp_bits", tag, c), 64'(o_comp_bits), 64'(v.e_bits));
        chk($sformatf("%s c%0d incompressible", tag, c), 64'(o_incompressible), 64'(v.e_inc));
      end
      @(posedge clk);
      #1;
    end
    tbl.delete();
    i_line_valid = 1'b0;
    i_stall      = 1'b0;
    i_done_ready = 1'b0;
  endtask

  task automatic chk_idle_outputs(input string tag);
    chk({tag, " line_ready"}, 64'(o_line_ready), 64'd1);
    chk({tag, " busy"}, 64'(o_busy), 64'd0);
    chk({tag, " dict_clr"}, 64'(o_dict_clr), 64'd0);
    chk({tag, " word_valid"}, 64'(o_word_valid), 64'd0);
    chk({tag, " word"}, o_word, 64'd0);
    chk({tag, " done_valid"}, 64'(o_done_valid), 64'd0);
    chk({tag, " comp_bits"}, 64'(o_comp_bits), 64'd0);
    chk({tag, " incompressible"}, 64'(o_incompressible), 64'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1);
  end

  initial begin
    line_zero = '0;
    for (int w = 0; w < 16; w++) line_dist[w*32 +: 32] = 32'h1000_0001 * (w + 1);
    active_line  = '0;
    i_reset      = 1'b0;
    i_line       = '0;
    i_line_valid = 1'b0;
    i_stall      = 1'b0;
    i_done_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk_idle_outputs("reset");
    @(posedge clk);
    #1;
    i_reset = 1'b1;

    // Compressible zero line.
    nominal(1'b0, 10'd32, 1'b0, 1'b0, 1'b0);
    run_table("zero");

`ifndef CPACK_EARLY_ABORT_EN
    // Incompressible line with stall toggled outside FEED.
    nominal(1'b1, 10'd544, 1'b1, 1'b1, 1'b0);
    run_table("dist");
`else
    // Abort once the total passes 200: pairs 0..4 only, 5*68 = 340.
    add(1, 1, 0, 0, 1, 0, 0, 0, -1, 0, 0);
    add(0, 1, 0, 0, 0, 1, 0, 0, -1, 0, 0);
    for (int p = 0; p < 5; p++) add(0, 1, 0, 0, 0, 0, 1, 0, p, 0, 0);
    add(0, 1, 0, 0, 0, 0, 0, 0, -1, 0, 0);
    add(0, 1, 0, 0, 0, 0, 0, 0, -1, 0, 0);
    add(0, 1, 0, 1, 0, 0, 0, 1, -1, 10'd340, 1);
    add(0, 1, 0, 0, 1, 0, 0, 0, -1, 0, 0);
    run_table("abort");
`endif

    // Stall in cycles 4..6: o_word holds pair 1, result moves to cycle 15.
    add(1, BIG, 0, 0, 1, 0, 0, 0, -1, 0, 0);
    add(0, BIG, 0, 0, 0, 1, 0, 0, -1, 0, 0);
    add(0, BIG, 0, 0, 0, 0, 1, 0, 0, 0, 0);
    add(0, BIG, 0, 0, 0, 0, 1, 0, 1, 0, 0);
    for (int s = 0; s < 3; s++) add(0, BIG, 1, 0, 0, 0, 0, 0, 1, 0, 0);
    for (int p = 2; p < 8; p++) add(0, BIG, 0, 0, 0, 0, 1, 0, p, 0, 0);
    add(0, BIG, 0, 0, 0, 0, 0, 0, -1, 0, 0);
    add(0, BIG, 0, 0, 0, 0, 0, 0, -1, 0, 0);
    add(0, BIG, 0, 1, 0, 0, 0, 1, -1, BIG ? 10'd544 : 10'd32, BIG);
    add(0, BIG, 0, 0, 1, 0, 0, 0, -1, 0, 0);
    run_table("stall");

    // Result held for 5 cycles while another line is offered; it is taken only after release.
    add(1, 0, 0, 0, 1, 0, 0, 0, -1, 0, 0);
    add(0, 0, 0, 0, 0, 1, 0, 0, -1, 0, 0);
    for (int p = 0; p < 8; p++) add(0, 0, 0, 0, 0, 0, 1, 0, p, 0, 0);
    add(0, 0, 0, 0, 0, 0, 0, 0, -1, 0, 0);
    add(0, 0, 0, 0, 0, 0, 0, 0, -1, 0, 0);
    for (int h = 0; h < 5; h++) add(1, BIG, 0, 0, 0, 0, 0, 1, -1, 10'd32, 0);
    add(1, BIG, 0, 1, 0, 0, 0, 1, -1, 10'd32, 0);
    add(1, BIG, 0, 0, 1, 0, 0, 0, -1, 0, 0);
    nominal(BIG, BIG ? 10'd544 : 10'd32, BIG, 1'b0, 1'b1);
    run_table("hold");

    // Reset asserted in cycle 6, mid-FEED, then a fresh line from scratch.
    nominal(1'b0, 10'd32, 1'b0, 1'b0, 1'b0);
    tbl = tbl[0:5];
    run_table("pre_rst");
    i_reset = 1'b0;
    #1;
    chk_idle_outputs("mid_rst");
    @(posedge clk);
    #1;
    i_reset = 1'b1;
    nominal(1'b0, 10'd32, 1'b0, 1'b0, 1'b0);
    run_table("post_rst");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire
